// File: rtl/alu_multicycle.sv
// Multi-cycle unsigned integer ALU: single-cycle ops finish at the accept edge,
// MUL (shift-add) and MOD (restoring division) take WIDTH iterations.
module alu_multicycle #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [3:0]       control,
   input  logic [WIDTH-1:0] a_bus,
   input  logic [WIDTH-1:0] b_bus,
   output logic [WIDTH-1:0] c_bus,
   output logic [WIDTH-1:0] c_hi,
   output logic             z_flag,
   output logic             c_flag,
   output logic             div0,
   output logic             busy,
   output logic             done
);

   localparam logic [3:0] OP_ADD   = 4'd1;
   localparam logic [3:0] OP_SUB   = 4'd2;
   localparam logic [3:0] OP_MUL   = 4'd3;
   localparam logic [3:0] OP_MOD   = 4'd4;
   localparam logic [3:0] OP_PASSA = 4'd5;
   localparam logic [3:0] OP_PASSB = 4'd6;
   localparam logic [3:0] OP_INC   = 4'd7;
   localparam logic [3:0] OP_DEC   = 4'd8;
   localparam logic [3:0] OP_CLR   = 4'd9;

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [WIDTH-1:0]     a_lat, b_lat, a_lat_nxt, b_lat_nxt;
   logic [2*WIDTH-1:0]   acc, acc_nxt;
   logic [WIDTH-1:0]     c_bus_nxt, c_hi_nxt;
   logic                 z_nxt, cf_nxt, div0_nxt, done_nxt;
   logic [WIDTH:0]       quick;
   logic                 quick_vld;
   logic [WIDTH:0]       mul_sum, div_shift, div_trial;
   logic [2*WIDTH-1:0]   mul_step, div_step;
   logic [WIDTH-1:0]     rem_final;

   // MUL: acc = {partial product, remaining multiplier bits}; add on LSB, then shift right.
   assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_lat} : {(WIDTH+1){1'b0}});
   assign mul_step = {mul_sum, acc[WIDTH-1:1]};

   // DIV: acc = {remainder, dividend bits}; bit WIDTH of the trial flags a failed subtract.
   assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_trial = div_shift - {1'b0, b_lat};
   assign div_step  = div_trial[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                       : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
   assign rem_final = (b_lat == '0) ? a_lat : div_step[2*WIDTH-1:WIDTH];

   assign busy = (state != S_IDLE);

   always_comb begin
      quick     = '0;
      quick_vld = 1'b1;
      case (control)
         OP_ADD:   quick = {1'b0, a_bus} + {1'b0, b_bus};
         OP_SUB:   quick = {1'b0, a_bus} - {1'b0, b_bus};
         OP_PASSA: quick = {1'b0, a_bus};
         OP_PASSB: quick = {1'b0, b_bus};
         OP_INC:   quick = {1'b0, a_bus} + (WIDTH+1)'(1);
         OP_DEC:   quick = {1'b0, a_bus} - (WIDTH+1)'(1);
         OP_CLR:   quick = '0;
         default:  quick_vld = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      a_lat_nxt = a_lat;
      b_lat_nxt = b_lat;
      acc_nxt   = acc;
      c_bus_nxt = c_bus;
      c_hi_nxt  = c_hi;
      z_nxt     = z_flag;
      cf_nxt    = c_flag;
      div0_nxt  = div0;
      done_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               a_lat_nxt = a_bus;
               b_lat_nxt = b_bus;
               cnt_nxt   = '0;
               if (control == OP_MUL) begin
                  state_nxt = S_MUL;
                  acc_nxt   = {{WIDTH{1'b0}}, b_bus};
               end else if (control == OP_MOD) begin
                  state_nxt = S_DIV;
                  acc_nxt   = {{WIDTH{1'b0}}, a_bus};
               end else begin
                  // Illegal opcodes still pulse done but leave every result untouched.
                  done_nxt = 1'b1;
                  if (quick_vld) begin
                     c_bus_nxt = quick[WIDTH-1:0];
                     c_hi_nxt  = '0;
                     z_nxt     = (quick[WIDTH-1:0] == '0);
                     cf_nxt    = quick[WIDTH];
                  end
               end
            end
         end
         S_MUL: begin
            acc_nxt = mul_step;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               c_bus_nxt = mul_step[WIDTH-1:0];
               c_hi_nxt  = mul_step[2*WIDTH-1:WIDTH];
               z_nxt     = (mul_step[WIDTH-1:0] == '0);
               cf_nxt    = 1'b0;
            end
         end
         S_DIV: begin
            acc_nxt = div_step;
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt == LAST) begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               done_nxt  = 1'b1;
               c_bus_nxt = rem_final;
               c_hi_nxt  = '0;
               z_nxt     = (rem_final == '0);
               cf_nxt    = 1'b0;
               div0_nxt  = (b_lat == '0);
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= '0;
         c_bus  <= '0;
         c_hi   <= '0;
         z_flag <= 1'b1;
         c_flag <= 1'b0;
         div0   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         c_bus  <= c_bus_nxt;
         c_hi   <= c_hi_nxt;
         z_flag <= z_nxt;
         c_flag <= cf_nxt;
         div0   <= div0_nxt;
         done   <= done_nxt;
      end
   end

   // Operand and iteration registers are only meaningful while busy, so they carry no reset.
   always_ff @(posedge clk) begin
      a_lat <= a_lat_nxt;
      b_lat <= b_lat_nxt;
      acc   <= acc_nxt;
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: 32-bit and 8-bit instances checked against a
// plain-arithmetic model, a fixed vector table, and handshake corner sequences.
module tb_alu_multicycle;

   logic        clk;
   logic        rst;
   logic        start32, start8;
   logic [3:0]  ctl32, ctl8;
   logic [31:0] a32, b32, c32, hi32;
   logic [7:0]  a8, b8, c8, hi8;
   logic        z32, cf32, d032, busy32, done32;
   logic        z8, cf8, d08, busy8, done8;

   alu_multicycle #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start32), .control(ctl32),
      .a_bus(a32), .b_bus(b32), .c_bus(c32), .c_hi(hi32),
      .z_flag(z32), .c_flag(cf32), .div0(d032), .busy(busy32), .done(done32));

   alu_multicycle #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .control(ctl8),
      .a_bus(a8), .b_bus(b8), .c_bus(c8), .c_hi(hi8),
      .z_flag(z8), .c_flag(cf8), .div0(d08), .busy(busy8), .done(done8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [63:0] c;
      logic [63:0] hi;
      logic        z;
      logic        cf;
      logic        d0;
   } exp_t;

   typedef struct {
      logic [3:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] c;
      logic [63:0] hi;
      logic        z;
      logic        cf;
      logic        d0;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   exp_t e32, e8;
   vec_t tbl [14];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, want);
      end
   endtask

   function automatic exp_t rst_exp();
      exp_t e;
      e   = '0;
      e.z = 1'b1;
      return e;
   endfunction

   // Reference: what the outputs should read after an op, and how many edges after accept done appears.
   function automatic exp_t model(input int w, input logic [3:0] op, input logic [63:0] a,
                                  input logic [63:0] b, input exp_t prev, output int edges);
      logic [63:0] mask, r;
      exp_t e;
      mask  = (64'd1 << w) - 64'd1;
      e     = prev;
      edges = 0;
      r     = 64'd0;
      case (op)
         4'd1: begin r = a + b; e.cf = ((r >> w) & 64'd1) != 64'd0; end
         4'd2: begin r = a - b; e.cf = (a < b); end
         4'd3: begin r = a * b; e.cf = 1'b0; edges = w; end
         4'd4: begin
            r     = (b == 64'd0) ? a : a % b;
            e.d0  = (b == 64'd0);
            e.cf  = 1'b0;
            edges = w;
         end
         4'd5: begin r = a; e.cf = 1'b0; end
         4'd6: begin r = b; e.cf = 1'b0; end
         4'd7: begin r = a + 64'd1; e.cf = (a == mask); end
         4'd8: begin r = a - 64'd1; e.cf = (a == 64'd0); end
         4'd9: begin r = 64'd0; e.cf = 1'b0; end
         default: return prev;
      endcase
      e.c  = r & mask;
      e.hi = (op == 4'd3) ? ((r >> w) & mask) : 64'd0;
      e.z  = (e.c == 64'd0);
      return e;
   endfunction

   function automatic exp_t observe(input bit sel);
      exp_t o;
      if (sel) begin
         o.c = 64'(c8);  o.hi = 64'(hi8);  o.z = z8;  o.cf = cf8;  o.d0 = d08;
      end else begin
         o.c = 64'(c32); o.hi = 64'(hi32); o.z = z32; o.cf = cf32; o.d0 = d032;
      end
      return o;
   endfunction

   function automatic logic [63:0] pick();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return 64'hFFFF_FFFF_FFFF_FFFF;
         2:       return 64'd1;
         default: return {$urandom, $urandom};
      endcase
   endfunction

   task automatic cmp_out(input string tag, input exp_t act, input exp_t want);
      chk({tag, " c_bus"},  act.c,       want.c);
      chk({tag, " c_hi"},   act.hi,      want.hi);
      chk({tag, " z_flag"}, 64'(act.z),  64'(want.z));
      chk({tag, " c_flag"}, 64'(act.cf), 64'(want.cf));
      chk({tag, " div0"},   64'(act.d0), 64'(want.d0));
   endtask

   task automatic drive(input bit sel, input logic st, input logic [3:0] op,
                        input logic [63:0] a, input logic [63:0] b);
      if (sel) begin
         start8 = st; ctl8 = op; a8 = a[7:0]; b8 = b[7:0];
      end else begin
         start32 = st; ctl32 = op; a32 = a[31:0]; b32 = b[31:0];
      end
   endtask

   // Called at a falling edge; returns at the falling edge where done is seen (so the next call is back-to-back).
   task automatic run_op(input bit sel, input logic [3:0] op, input logic [63:0] a_in,
                         input logic [63:0] b_in, input int gap, input string tag);
      int          w, edges_exp, edges, busy_bad;
      logic [63:0] a, b, mask;
      logic        d, bz;
      exp_t        e;
      w    = sel ? 8 : 32;
      mask = (64'd1 << w) - 64'd1;
      a    = a_in & mask;
      b    = b_in & mask;
      e    = model(w, op, a, b, sel ? e8 : e32, edges_exp);
      drive(sel, 1'b1, op, a, b);
      @(posedge clk);
      @(negedge clk);
      drive(sel, 1'b0, 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
      edges    = 0;
      busy_bad = 0;
      d  = sel ? done8 : done32;
      bz = sel ? busy8 : busy32;
      while (!d && edges < edges_exp + 4) begin
         if (bz != (edges_exp > 0)) busy_bad++;
         @(negedge clk);
         edges++;
         d  = sel ? done8 : done32;
         bz = sel ? busy8 : busy32;
      end
      if (d && bz) busy_bad++;
      chk({tag, " done edge"}, 64'(edges), 64'(edges_exp));
      chk({tag, " busy"}, 64'(busy_bad), 64'd0);
      cmp_out(tag, observe(sel), e);
      if (sel) e8 = e; else e32 = e;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         if (g == 0) chk({tag, " done width"}, 64'(sel ? done8 : done32), 64'd0);
      end
   endtask

   task automatic ignored_start_seq();
      int   ee, edges, busyhi;
      exp_t e;
      e = model(32, 4'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF, e32, ee);
      drive(1'b0, 1'b1, 4'd3, 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      @(posedge clk);
      @(negedge clk);
      drive(1'b0, 1'b0, 4'd3, 64'd0, 64'd0);
      edges  = 0;
      busyhi = 0;
      while (!done32 && edges < 40) begin
         if (busy32) busyhi++;
         if (edges == 5) drive(1'b0, 1'b1, 4'd1, 64'd1, 64'd1);
         else if (edges == 6) drive(1'b0, 1'b0, 4'd1, 64'd1, 64'd1);
         @(negedge clk);
         edges++;
      end
      chk("mul ignore done edge", 64'(edges), 64'd32);
      chk("mul ignore busy cycles", 64'(busyhi), 64'd32);
      cmp_out("mul ignore", observe(1'b0), e);
      e32 = e;
      @(negedge clk);
      chk("mul ignore no extra done", 64'(done32), 64'd0);
      chk("mul ignore c_bus held", 64'(c32), 64'h1);
   endtask

   task automatic reset_seq();
      int dones;
      run_op(1'b0, 4'd4, 64'd9, 64'd0, 0, "pre-reset mod");
      drive(1'b0, 1'b1, 4'd3, 64'hFFFF_FFFF, 64'd3);
      @(posedge clk);
      for (int k = 0; k <= 10; k++) begin
         @(negedge clk);
         if (k == 0) drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
      end
      rst = 1'b1;
      #1;
      cmp_out("abort", observe(1'b0), rst_exp());
      chk("abort busy", 64'(busy32), 64'd0);
      chk("abort done", 64'(done32), 64'd0);
      cmp_out("abort w8", observe(1'b1), rst_exp());
      @(negedge clk);
      rst   = 1'b0;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (done32 || busy32) dones++;
      end
      chk("abort no done", 64'(dones), 64'd0);
      e32 = rst_exp();
      e8  = rst_exp();
      run_op(1'b0, 4'd1, 64'd3, 64'd4, 1, "add after reset");
      chk("add after reset value", 64'(c32), 64'd7);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      //        op     a                 b                c                hi               z     cf    d0
      tbl[0]  = '{4'd1,  64'hFFFF_FFFF, 64'h2,         64'h1,           64'h0,           1'b0, 1'b1, 1'b0};
      tbl[1]  = '{4'd2,  64'h1234,      64'h1234,      64'h0,           64'h0,           1'b1, 1'b0, 1'b0};
      tbl[2]  = '{4'd8,  64'h0,         64'h0,         64'hFFFF_FFFF,   64'h0,           1'b0, 1'b1, 1'b0};
      tbl[3]  = '{4'd3,  64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'h1,           64'hFFFF_FFFE,   1'b0, 1'b0, 1'b0};
      tbl[4]  = '{4'd4,  64'd100,       64'd7,         64'd2,           64'h0,           1'b0, 1'b0, 1'b0};
      tbl[5]  = '{4'd4,  64'd55,        64'd0,         64'd55,          64'h0,           1'b0, 1'b0, 1'b1};
      tbl[6]  = '{4'd5,  64'h0,         64'h5,         64'h0,           64'h0,           1'b1, 1'b0, 1'b1};
      tbl[7]  = '{4'd6,  64'h1,         64'hA5,        64'hA5,          64'h0,           1'b0, 1'b0, 1'b1};
      tbl[8]  = '{4'd7,  64'h7FFF_FFFF, 64'h0,         64'h8000_0000,   64'h0,           1'b0, 1'b0, 1'b1};
      tbl[9]  = '{4'd15, 64'h1,         64'h2,         64'h8000_0000,   64'h0,           1'b0, 1'b0, 1'b1};
      tbl[10] = '{4'd9,  64'h7,         64'h9,         64'h0,           64'h0,           1'b1, 1'b0, 1'b1};
      tbl[11] = '{4'd4,  64'hFFFF_FFFF, 64'h10,        64'hF,           64'h0,           1'b0, 1'b0, 1'b0};
      tbl[12] = '{4'd4,  64'd6,         64'd3,         64'd0,           64'h0,           1'b1, 1'b0, 1'b0};
      tbl[13] = '{4'd3,  64'h1_0000,    64'h1_0000,    64'h0,           64'h1,           1'b1, 1'b0, 1'b0};

      rst = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 64'd0, 64'd0);
      drive(1'b1, 1'b0, 4'd0, 64'd0, 64'd0);
      repeat (2) @(negedge clk);
      cmp_out("reset", observe(1'b0), rst_exp());
      cmp_out("reset w8", observe(1'b1), rst_exp());
      chk("reset busy", 64'(busy32), 64'd0);
      chk("reset done", 64'(done32), 64'd0);
      rst = 1'b0;
      e32 = rst_exp();
      e8  = rst_exp();
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         exp_t want;
         run_op(1'b0, tbl[i].op, tbl[i].a, tbl[i].b, i % 2, $sformatf("tbl%0d", i));
         want = '{c: tbl[i].c, hi: tbl[i].hi, z: tbl[i].z, cf: tbl[i].cf, d0: tbl[i].d0};
         cmp_out($sformatf("tbl%0d const", i), observe(1'b0), want);
      end

      ignored_start_seq();

      run_op(1'b1, 4'd3, 64'hFF, 64'hFF, 0, "mul8");
      chk("mul8 c_bus", 64'(c8), 64'h01);
      chk("mul8 c_hi", 64'(hi8), 64'hFE);
      run_op(1'b1, 4'd6, 64'h3C, 64'hA5, 1, "passb8 b2b");
      chk("passb8 c_bus", 64'(c8), 64'hA5);

      reset_seq();

      for (int i = 0; i < 150; i++) begin
         bit sel;
         sel = ($urandom_range(0, 3) == 0);
         run_op(sel, 4'($urandom_range(0, 15)), pick(), pick(), $urandom_range(0, 2),
                $sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
